// File: rtl/display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : display_arbiter
// Brief  : Single-port framebuffer RAM arbiter, priority HDMI > clear > CPU.
//          Macro CLEAR_ENGINE_EN enables the full-screen clear engine.
// Rev    : 1.0  initial release
// ============================================================================
module display_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  hdmi_req_in,
  input  logic [ADDR_WIDTH-1:0] hdmi_addr_in,
  output logic [DATA_WIDTH-1:0] hdmi_data_out,
  input  logic                  cpu_valid_in,
  output logic                  cpu_ready_out,
  input  logic                  cpu_we_in,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_in,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_in,
  output logic                  cpu_rvalid_out,
  output logic [DATA_WIDTH-1:0] cpu_rdata_out,
  input  logic                  clear_start_in,
  output logic                  clear_busy_out,
  output logic                  clear_done_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_we_out,
  output logic [DATA_WIDTH-1:0] mem_din_out,
  input  logic [DATA_WIDTH-1:0] mem_dout_in
);

  localparam int TAG_DEPTH = 1 + MEM_LATENCY;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_HDMI = 2'd1,
    TAG_CPU  = 2'd2
  } tag_t;

  tag_t                  r_tag [TAG_DEPTH];
  logic                  w_idle;
  logic                  w_cpu_hs;
  logic                  w_clr_wr;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_gnt_we;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [DATA_WIDTH-1:0] w_gnt_din;
  tag_t                  w_gnt_tag;

`ifdef CLEAR_ENGINE_EN
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
  logic                  r_clr_done;
  logic                  w_clr_done_nxt;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_clr_done <= w_clr_done_nxt;
    end
  end

  // The clear only advances in cycles the video reader leaves the RAM free.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_clr_done_nxt = 1'b0;
    w_clr_wr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_start_in) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (!hdmi_req_in) begin
          w_clr_wr      = 1'b1;
          w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
          if (r_clr_cnt == '1) begin
            w_state_nxt    = S_IDLE;
            w_clr_done_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clr_addr     = r_clr_cnt;
  assign w_idle         = (r_state == S_IDLE);
  assign clear_busy_out = (r_state == S_CLEAR);
  assign clear_done_out = r_clr_done;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_start_in;
  assign w_clr_wr       = 1'b0;
  assign w_clr_addr     = '0;
  assign w_idle         = 1'b1;
  assign clear_busy_out = 1'b0;
  assign clear_done_out = 1'b0;
`endif

  assign cpu_ready_out = rst_in && !hdmi_req_in && w_idle;
  assign w_cpu_hs      = cpu_valid_in && cpu_ready_out;

  always_comb begin
    w_gnt_we   = 1'b0;
    w_gnt_addr = '0;
    w_gnt_din  = '0;
    w_gnt_tag  = TAG_NONE;
    if (hdmi_req_in) begin
      w_gnt_addr = hdmi_addr_in;
      w_gnt_tag  = TAG_HDMI;
    end else if (w_clr_wr) begin
      w_gnt_we   = 1'b1;
      w_gnt_addr = w_clr_addr;
    end else if (w_cpu_hs) begin
      w_gnt_we   = cpu_we_in;
      w_gnt_addr = cpu_addr_in;
      w_gnt_din  = cpu_we_in ? cpu_wdata_in : '0;
      w_gnt_tag  = cpu_we_in ? TAG_NONE : TAG_CPU;
    end
  end

  // Tags ride alongside the RAM latency so each return reaches its requester.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mem_addr_out   <= '0;
      mem_we_out     <= 1'b0;
      mem_din_out    <= '0;
      hdmi_data_out  <= '0;
      cpu_rdata_out  <= '0;
      cpu_rvalid_out <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= TAG_NONE;
    end else begin
      mem_addr_out   <= w_gnt_addr;
      mem_we_out     <= w_gnt_we;
      mem_din_out    <= w_gnt_din;
      r_tag[0]       <= w_gnt_tag;
      for (int i = 1; i < TAG_DEPTH; i++) r_tag[i] <= r_tag[i-1];
      cpu_rvalid_out <= (r_tag[TAG_DEPTH-1] == TAG_CPU);
      if (r_tag[TAG_DEPTH-1] == TAG_HDMI) hdmi_data_out <= mem_dout_in;
      if (r_tag[TAG_DEPTH-1] == TAG_CPU)  cpu_rdata_out <= mem_dout_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for display_arbiter with a 1-cycle-latency RAM model.
module tb_display_arbiter;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       hdmi_req_in = 1'b0;
  logic [7:0] hdmi_addr_in = 8'h00;
  logic [7:0] hdmi_data_out;
  logic       cpu_valid_in = 1'b0;
  logic       cpu_ready_out;
  logic       cpu_we_in = 1'b0;
  logic [7:0] cpu_addr_in = 8'h00;
  logic [7:0] cpu_wdata_in = 8'h00;
  logic       cpu_rvalid_out;
  logic [7:0] cpu_rdata_out;
  logic       clear_start_in = 1'b0;
  logic       clear_busy_out;
  logic       clear_done_out;
  logic [7:0] mem_addr_out;
  logic       mem_we_out;
  logic [7:0] mem_din_out;
  logic [7:0] mem_dout_in;

  logic [7:0] ram [256];
  logic       bd_fill = 1'b0;
  logic       bd_ident = 1'b0;
  logic       bd_we = 1'b0;
  logic [7:0] bd_val = 8'h00;
  logic [7:0] bd_addr = 8'h00;

  int checks = 0;
  int errors = 0;

  display_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hdmi_req_in(hdmi_req_in), .hdmi_addr_in(hdmi_addr_in), .hdmi_data_out(hdmi_data_out),
    .cpu_valid_in(cpu_valid_in), .cpu_ready_out(cpu_ready_out), .cpu_we_in(cpu_we_in),
    .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in),
    .cpu_rvalid_out(cpu_rvalid_out), .cpu_rdata_out(cpu_rdata_out),
    .clear_start_in(clear_start_in), .clear_busy_out(clear_busy_out), .clear_done_out(clear_done_out),
    .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_din_out(mem_din_out),
    .mem_dout_in(mem_dout_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (bd_fill)         for (int i = 0; i < 256; i++) ram[i] <= bd_val;
    else if (bd_ident)   for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
    else if (bd_we)      ram[bd_addr] <= bd_val;
    else if (mem_we_out) ram[mem_addr_out] <= mem_din_out;
    mem_dout_in <= ram[mem_addr_out];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       hreq;
    logic [7:0] haddr;
    logic       cv;
    logic       cwe;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       e_rdy;
    logic       e_mwe;
    logic [7:0] e_maddr;
    logic [7:0] e_mdin;
    logic       e_rv;
    logic [7:0] e_rdata;
    logic [7:0] e_hd;
  } vec_t;

  vec_t vecs [19];

  int   n;
  int   k;
  int   bad;
  int   rdy_hi;
  int   done_seen;
  logic p1_req, p2_req, hd_known;
  logic [7:0] p1_a, p2_a, exp_hd;

  initial begin
    // hreq haddr cv cwe caddr cwd | rdy mwe maddr mdin rv rdata hd
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[3]  = '{1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[4]  = '{1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h04, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[5]  = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 8'hA5};
    vecs[6]  = '{1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h06, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[7]  = '{1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 8'h11};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h11};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h11};
    vecs[14] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h3C, 8'h11};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h3C, 8'h11};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h3C};
    vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h3C};
    vecs[18] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'h20, 8'h99, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5, 8'h3C};

    // Reset with RAM preloaded to 0x11 except 0xA5 at 0x03
    bd_fill = 1'b1; bd_val = 8'h11;
    step();
    bd_fill = 1'b0; bd_we = 1'b1; bd_addr = 8'h03; bd_val = 8'hA5;
    step();
    bd_we = 1'b0;
    step();
    chk("rst_hdmi_data", hdmi_data_out, 8'h00);
    chk("rst_rdata", cpu_rdata_out, 8'h00);
    chk("rst_rvalid", cpu_rvalid_out, 1'b0);
    chk("rst_mem_we", mem_we_out, 1'b0);
    chk("rst_mem_addr", mem_addr_out, 8'h00);
    chk("rst_mem_din", mem_din_out, 8'h00);
    chk("rst_busy", clear_busy_out, 1'b0);
    chk("rst_done", clear_done_out, 1'b0);
    chk("rst_ready_low", cpu_ready_out, 1'b0);
    rst_in = 1'b1;
    #1;
    chk("rst_ready_after", cpu_ready_out, 1'b1);

    for (int i = 0; i < 19; i++) begin
      hdmi_req_in = vecs[i].hreq; hdmi_addr_in = vecs[i].haddr;
      cpu_valid_in = vecs[i].cv; cpu_we_in = vecs[i].cwe;
      cpu_addr_in = vecs[i].caddr; cpu_wdata_in = vecs[i].cwd;
      #1;
      chk($sformatf("v%0d_ready", i), cpu_ready_out, vecs[i].e_rdy);
      step();
      chk($sformatf("v%0d_mem_we", i), mem_we_out, vecs[i].e_mwe);
      chk($sformatf("v%0d_mem_addr", i), mem_addr_out, vecs[i].e_maddr);
      chk($sformatf("v%0d_mem_din", i), mem_din_out, vecs[i].e_mdin);
      chk($sformatf("v%0d_rvalid", i), cpu_rvalid_out, vecs[i].e_rv);
      chk($sformatf("v%0d_rdata", i), cpu_rdata_out, vecs[i].e_rdata);
      chk($sformatf("v%0d_hdmi_data", i), hdmi_data_out, vecs[i].e_hd);
    end
    hdmi_req_in = 1'b0; cpu_valid_in = 1'b0;
    step();

    // CPU write stalled by five HDMI cycles, then read-back
    bd_we = 1'b1; bd_addr = 8'h10; bd_val = 8'h00;
    step();
    bd_we = 1'b0;
    cpu_valid_in = 1'b1; cpu_we_in = 1'b1; cpu_addr_in = 8'h10; cpu_wdata_in = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      hdmi_req_in = 1'b1; hdmi_addr_in = 8'(c);
      #1;
      chk("stall_ready", cpu_ready_out, 1'b0);
      step();
      chk("stall_mem_we", mem_we_out, 1'b0);
    end
    hdmi_req_in = 1'b0;
    #1;
    chk("stall_ready_c6", cpu_ready_out, 1'b1);
    step();
    cpu_valid_in = 1'b0;
    chk("stall_wr_we", mem_we_out, 1'b1);
    chk("stall_wr_addr", mem_addr_out, 8'h10);
    chk("stall_wr_din", mem_din_out, 8'h3C);
    cpu_valid_in = 1'b1; cpu_we_in = 1'b0;
    step();
    cpu_valid_in = 1'b0;
    chk("rd_rvalid_t1", cpu_rvalid_out, 1'b0);
    step();
    chk("rd_rvalid_t2", cpu_rvalid_out, 1'b0);
    step();
    chk("rd_rvalid_t3", cpu_rvalid_out, 1'b1);
    chk("rd_rdata", cpu_rdata_out, 8'h3C);
    step();
    chk("rd_rvalid_end", cpu_rvalid_out, 1'b0);
    chk("ram_0x10", ram[8'h10], 8'h3C);

`ifdef CLEAR_ENGINE_EN
    // Clear with HDMI idle; CPU write in the start cycle, CPU read held pending
    bd_fill = 1'b1; bd_val = 8'hFF;
    step();
    bd_fill = 1'b0;
    clear_start_in = 1'b1;
    cpu_valid_in = 1'b1; cpu_we_in = 1'b1; cpu_addr_in = 8'h40; cpu_wdata_in = 8'h99;
    #1;
    chk("clr1_start_ready", cpu_ready_out, 1'b1);
    step();
    clear_start_in = 1'b0; cpu_we_in = 1'b0;
    chk("clr1_start_wr", {mem_we_out, mem_addr_out, mem_din_out}, {1'b1, 8'h40, 8'h99});
    n = 0; rdy_hi = 0; done_seen = 0;
    while (clear_busy_out && n < 1000) begin
      #1;
      if (cpu_ready_out) rdy_hi++;
      if (clear_done_out) done_seen++;
      step();
      n++;
    end
    chk("clr1_busy_cycles", n, 256);
    chk("clr1_ready_high", rdy_hi, 0);
    chk("clr1_done_early", done_seen, 0);
    chk("clr1_done", clear_done_out, 1'b1);
    #1;
    chk("clr1_ready_after", cpu_ready_out, 1'b1);
    step();
    cpu_valid_in = 1'b0;
    chk("clr1_done_pulse", clear_done_out, 1'b0);
    step();
    step();
    chk("clr1_rd_rvalid", cpu_rvalid_out, 1'b1);
    chk("clr1_rd_rdata", cpu_rdata_out, 8'h00);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 8'h00) bad++;
    chk("clr1_nonzero_bytes", bad, 0);

    // Clear with HDMI toggling; restart attempt mid-clear
    bd_ident = 1'b1;
    step();
    bd_ident = 1'b0;
    clear_start_in = 1'b1;
    step();
    clear_start_in = 1'b0;
    cpu_valid_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 8'h05;
    k = 0; rdy_hi = 0; hd_known = 1'b0;
    p1_req = 1'b0; p2_req = 1'b0; p1_a = 8'h00; p2_a = 8'h00; exp_hd = 8'h00;
    while (clear_busy_out && k < 2000) begin
      hdmi_req_in = ~k[0]; hdmi_addr_in = {1'b1, k[6:0]}; clear_start_in = (k == 100);
      #1;
      if (cpu_ready_out) rdy_hi++;
      step();
      if (p2_req) begin exp_hd = p2_a; hd_known = 1'b1; end
      if (hd_known && k < 200) chk("clr2_hdmi_latency", hdmi_data_out, exp_hd);
      p2_req = p1_req; p2_a = p1_a; p1_req = hdmi_req_in; p1_a = hdmi_addr_in;
      k++;
    end
    hdmi_req_in = 1'b0; clear_start_in = 1'b0;
    chk("clr2_busy_cycles", k, 512);
    chk("clr2_ready_high", rdy_hi, 0);
    chk("clr2_done", clear_done_out, 1'b1);
    step();
    cpu_valid_in = 1'b0;
    step();
    step();
    chk("clr2_rd_rvalid", cpu_rvalid_out, 1'b1);
    chk("clr2_rd_rdata", cpu_rdata_out, 8'h00);

    // Reset at counter 0x40 with a read from the start cycle
    bd_fill = 1'b1; bd_val = 8'hFF;
    step();
    bd_fill = 1'b0;
    clear_start_in = 1'b1; cpu_valid_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 8'h80;
    step();
    clear_start_in = 1'b0; cpu_valid_in = 1'b0;
    step();
    step();
    chk("clr3_start_rvalid", cpu_rvalid_out, 1'b1);
    chk("clr3_start_rdata", cpu_rdata_out, 8'hFF);
    for (int i = 0; i < 62; i++) step();
    rst_in = 1'b0;
    step();
    chk("clr3_rst_busy", clear_busy_out, 1'b0);
    chk("clr3_rst_done", clear_done_out, 1'b0);
    chk("clr3_rst_mem", {mem_we_out, mem_addr_out, mem_din_out}, 17'h0);
    chk("clr3_rst_rd", {cpu_rvalid_out, cpu_rdata_out, hdmi_data_out}, 17'h0);
    chk("clr3_rst_ready", cpu_ready_out, 1'b0);
    rst_in = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (clear_done_out || clear_busy_out) done_seen++;
    end
    chk("clr3_no_done", done_seen, 0);
    chk("clr3_ram_3f", ram[8'h3F], 8'h00);
    chk("clr3_ram_40", ram[8'h40], 8'hFF);
    // Reset while a CPU read is in flight
    cpu_valid_in = 1'b1; cpu_addr_in = 8'h80;
    step();
    cpu_valid_in = 1'b0; rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cpu_rvalid_out) bad++;
    end
    chk("rst_midread_rvalid", bad, 0);
    // New clear restarts from 0x00
    clear_start_in = 1'b1;
    step();
    clear_start_in = 1'b0;
    step();
    chk("clr4_first_write", {mem_we_out, mem_addr_out, mem_din_out}, {1'b1, 8'h00, 8'h00});
    n = 0;
    while (clear_busy_out && n < 1000) begin
      step();
      n++;
    end
    chk("clr4_busy_cycles", n, 255);
    step();
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 8'h00) bad++;
    chk("clr4_nonzero_bytes", bad, 0);
`else
    // Clear engine absent: start pulse has no effect
    bd_fill = 1'b1; bd_val = 8'hFF;
    step();
    bd_fill = 1'b0;
    clear_start_in = 1'b1;
    #1;
    chk("noclr_ready", cpu_ready_out, 1'b1);
    step();
    clear_start_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (clear_busy_out || clear_done_out || mem_we_out || !cpu_ready_out) bad++;
      step();
    end
    chk("noclr_activity", bad, 0);
    chk("noclr_ram_00", ram[8'h00], 8'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
